// File: rtl/multdiv_issue_ctrl.sv
// Issue controller for the iterative multiply/divide unit: latches one request,
// strobes the unit, stalls the pipe, and holds the result (or a timeout) for writeback.
module multdiv_issue_ctrl #(
  parameter int unsigned LATENCY_MAX = 40,
  parameter int unsigned RD_W        = 5
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            op_valid,
  input  logic            op_is_div,
  input  logic [31:0]     op_a,
  input  logic [31:0]     op_b,
  input  logic [RD_W-1:0] op_rd,
  output logic [31:0]     md_operandA,
  output logic [31:0]     md_operandB,
  output logic            md_ctrl_MULT,
  output logic            md_ctrl_DIV,
  input  logic [31:0]     md_result,
  input  logic            md_exception,
  input  logic            md_resultRDY,
  output logic            stall,
  output logic            wb_valid,
  output logic [31:0]     wb_data,
  output logic            wb_exception,
  output logic [RD_W-1:0] wb_rd,
  input  logic            wb_ack,
  output logic            busy
);

  localparam int unsigned WD_W = $clog2(LATENCY_MAX);
  // The watchdog counts WAIT cycles; WAIT starts one cycle after the strobe.
  localparam logic [WD_W-1:0] WD_FIRE = WD_W'(LATENCY_MAX - 2);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t          state, state_nxt;
  logic [WD_W-1:0] wd, wd_d;
  logic            is_div_q, is_div_d;
  logic [RD_W-1:0] rd_q, rd_d;
  logic [31:0]     opa_d, opb_d, wb_data_d;
  logic            wb_exception_d;
  logic [RD_W-1:0] wb_rd_d;
  logic            mult_d, div_d, wb_valid_d, busy_d;
  logic            accept_c, ready_c, timeout_c;

  assign accept_c  = (state == IDLE) && op_valid;
  assign ready_c   = (state == WAIT) && md_resultRDY;
  assign timeout_c = (state == WAIT) && (wd == WD_FIRE);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (op_valid) state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT:    if (md_resultRDY || timeout_c) state_nxt = DONE;
      DONE:    if (wb_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values for every registered output and internal register.
  always_comb begin
    opa_d          = md_operandA;
    opb_d          = md_operandB;
    rd_d           = rd_q;
    is_div_d       = is_div_q;
    wd_d           = wd;
    wb_data_d      = wb_data;
    wb_exception_d = wb_exception;
    wb_rd_d        = wb_rd;
    if (accept_c) begin
      opa_d    = op_a;
      opb_d    = op_b;
      rd_d     = op_rd;
      is_div_d = op_is_div;
    end
    if (state == START) wd_d = '0;
    else if (state == WAIT) wd_d = wd + WD_W'(1);
    // Ready has priority over a coincident timeout.
    if (ready_c) begin
      wb_data_d      = md_result;
      wb_exception_d = md_exception;
      wb_rd_d        = rd_q;
    end else if (timeout_c) begin
      wb_data_d      = '0;
      wb_exception_d = 1'b1;
      wb_rd_d        = rd_q;
    end
    mult_d     = accept_c && !op_is_div;
    div_d      = accept_c && op_is_div;
    wb_valid_d = (state_nxt == DONE);
    busy_d     = (state_nxt != IDLE);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      md_operandA  <= '0;
      md_operandB  <= '0;
      rd_q         <= '0;
      is_div_q     <= 1'b0;
      wd           <= '0;
      wb_data      <= '0;
      wb_exception <= 1'b0;
      wb_rd        <= '0;
      md_ctrl_MULT <= 1'b0;
      md_ctrl_DIV  <= 1'b0;
      wb_valid     <= 1'b0;
      busy         <= 1'b0;
      stall        <= 1'b0;
    end else begin
      md_operandA  <= opa_d;
      md_operandB  <= opb_d;
      rd_q         <= rd_d;
      is_div_q     <= is_div_d;
      wd           <= wd_d;
      wb_data      <= wb_data_d;
      wb_exception <= wb_exception_d;
      wb_rd        <= wb_rd_d;
      md_ctrl_MULT <= mult_d;
      md_ctrl_DIV  <= div_d;
      wb_valid     <= wb_valid_d;
      busy         <= busy_d;
      stall        <= busy_d;
    end
  end

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Directed bench for multdiv_issue_ctrl; the bench itself plays the mult/div unit.
module tb_multdiv_issue_ctrl;

  logic        clock = 1'b0;
  logic        resetn;
  logic        op_valid, op_is_div;
  logic [31:0] op_a, op_b;
  logic [4:0]  op_rd;
  logic [31:0] md_operandA, md_operandB;
  logic        md_ctrl_MULT, md_ctrl_DIV;
  logic [31:0] md_result;
  logic        md_exception, md_resultRDY;
  logic        stall, wb_valid;
  logic [31:0] wb_data;
  logic        wb_exception;
  logic [4:0]  wb_rd;
  logic        wb_ack, busy;

  int n_checks = 0;
  int n_errors = 0;

  multdiv_issue_ctrl #(.LATENCY_MAX(40), .RD_W(5)) dut (
    .clock(clock), .resetn(resetn),
    .op_valid(op_valid), .op_is_div(op_is_div), .op_a(op_a), .op_b(op_b), .op_rd(op_rd),
    .md_operandA(md_operandA), .md_operandB(md_operandB),
    .md_ctrl_MULT(md_ctrl_MULT), .md_ctrl_DIV(md_ctrl_DIV),
    .md_result(md_result), .md_exception(md_exception), .md_resultRDY(md_resultRDY),
    .stall(stall), .wb_valid(wb_valid), .wb_data(wb_data), .wb_exception(wb_exception),
    .wb_rd(wb_rd), .wb_ack(wb_ack), .busy(busy)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL global_timeout: observed hang expected finish");
    $fatal(1, "bench timed out");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [127:0] all_outs();
    return 128'({md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV, stall, wb_valid,
                 wb_data, wb_exception, wb_rd, busy});
  endfunction

  // Issue in the current cycle (cycle 0); the unit answers in cycle 33.
  task automatic do_op(input logic div, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] res, input logic exc);
    op_valid = 1'b1; op_is_div = div; op_a = a; op_b = b; op_rd = rd;
    tick();
    op_valid = 1'b0; op_a = 32'hDEAD_BEEF; op_b = 32'h1234_5678; op_rd = 5'd31;
    check("strobe_c1", 128'({md_ctrl_MULT, md_ctrl_DIV}), 128'({~div, div}));
    check("stall_c1", 128'({stall, busy}), 128'(2'b11));
    check("opa_c1", 128'(md_operandA), 128'(a));
    for (int c = 2; c <= 33; c++) begin
      tick();
      check("strobe_quiet", 128'({md_ctrl_MULT, md_ctrl_DIV}), 128'(0));
      check("wait_state", 128'({stall, wb_valid}), 128'(2'b10));
    end
    md_resultRDY = 1'b1; md_result = res; md_exception = exc;
    tick();
    md_resultRDY = 1'b0; md_result = 32'h0BAD_0BAD; md_exception = 1'b0;
    check("wb_valid_c34", 128'(wb_valid), 128'(1));
    check("wb_data", 128'(wb_data), 128'(res));
    check("wb_exc", 128'(wb_exception), 128'(exc));
    check("wb_rd", 128'(wb_rd), 128'(rd));
    check("operands_held", 128'({md_operandA, md_operandB}), 128'({a, b}));
    check("stall_c34", 128'(stall), 128'(1));
  endtask

  task automatic do_ack();
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    check("after_ack", 128'({busy, stall, wb_valid}), 128'(0));
  endtask

  initial begin
    resetn = 1'b0; op_valid = 1'b0; op_is_div = 1'b0; op_a = '0; op_b = '0; op_rd = '0;
    md_result = '0; md_exception = 1'b0; md_resultRDY = 1'b0; wb_ack = 1'b0;
    #2;
    check("reset_outputs", all_outs(), 128'(0));
    tick(); tick();
    resetn = 1'b1;
    tick();
    check("idle_after_reset", all_outs(), 128'(0));

    // MULT 7 x -3
    do_op(1'b0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 1'b0);
    do_op_ack_stray: begin
      wb_ack = 1'b0;
    end
    do_ack();

    // DIV -100 / 7, then hold without ack
    do_op(1'b1, 32'hFFFF_FF9C, 32'd7, 5'd9, 32'hFFFF_FFF2, 1'b0);
    repeat (10) begin
      tick();
      check("hold_wb", 128'({wb_valid, wb_data, wb_exception, wb_rd}),
            128'({1'b1, 32'hFFFF_FFF2, 1'b0, 5'd9}));
    end
    do_ack();

    // DIV 5 / 0 and MULT overflow: exceptions pass through
    do_op(1'b1, 32'd5, 32'd0, 5'd3, 32'd0, 1'b1);
    do_ack();
    do_op(1'b0, 32'h0001_0000, 32'h0001_0000, 5'd4, 32'd0, 1'b1);
    do_ack();

    // Ready while IDLE is ignored
    md_resultRDY = 1'b1; md_result = 32'h5555_5555; md_exception = 1'b1;
    tick();
    md_resultRDY = 1'b0;
    check("idle_ready_ignored", 128'({wb_valid, busy, wb_data}), 128'({1'b0, 1'b0, 32'd0}));

    // Watchdog: only a stray ready in START, then silence; fires at cycle 41
    op_valid = 1'b1; op_is_div = 1'b1; op_a = 32'd11; op_b = 32'd2; op_rd = 5'd17;
    tick();
    op_valid = 1'b0;
    check("wd_strobe", 128'({md_ctrl_MULT, md_ctrl_DIV}), 128'(2'b01));
    md_resultRDY = 1'b1; md_result = 32'h7777_7777;
    tick();
    md_resultRDY = 1'b0;
    check("start_ready_ignored", 128'(wb_valid), 128'(0));
    for (int c = 3; c <= 40; c++) begin
      tick();
      check("wd_quiet", 128'({md_ctrl_MULT, md_ctrl_DIV, wb_valid}), 128'(0));
    end
    tick();
    check("wd_fire", 128'({wb_valid, wb_data, wb_exception, wb_rd}),
          128'({1'b1, 32'd0, 1'b1, 5'd17}));
    do_ack();

    // Reset in cycle 15 of a MULT; late ready at cycle 33 must be ignored
    op_valid = 1'b1; op_is_div = 1'b0; op_a = 32'd6; op_b = 32'd7; op_rd = 5'd2;
    tick();
    op_valid = 1'b0;
    repeat (14) tick();
    resetn = 1'b0;
    #1;
    check("midop_reset", all_outs(), 128'(0));
    tick();
    resetn = 1'b1;
    repeat (17) tick();
    md_resultRDY = 1'b1; md_result = 32'd42;
    tick();
    md_resultRDY = 1'b0;
    check("late_ready_ignored", 128'({wb_valid, busy, wb_data}), 128'(0));

    // Normal op after reset recovery
    do_op(1'b0, 32'd6, 32'd7, 5'd2, 32'd42, 1'b0);
    do_ack();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
